// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W bits LSB first, optional even parity, stop bits.
// Accepts one word per frame through a valid/ready handshake; tx is driven straight from a flop.
//
// state  | meaning
// IDLE   | line high, in_ready=1, waiting for in_valid
// START  | start bit (tx=0)
// DATA   | payload bits, LSB first
// PARITY | even parity bit (only when PARITY_EN=1)
// STOP   | stop bit(s), tx=1
module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int IW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int NXT = (DATA_W > 1) ? 1 : 0;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] BIT_LAST = IW'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [IW-1:0]     bit_idx;
   logic              stop_idx;
   logic [DATA_W-1:0] shreg;
   logic              par;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par      <= 1'b0;
         tx       <= 1'b1;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (in_valid) begin
                  shreg <= in_data;
                  par   <= ^in_data;
                  cnt   <= '0;
                  tx    <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  tx      <= shreg[0];
                  state   <= DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (bit_idx == BIT_LAST) begin
                     stop_idx <= 1'b0;
                     if (PARITY_EN != 0) begin
                        tx    <= par;
                        state <= PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     // next bit sits at index 1 before the shift lands
                     bit_idx <= bit_idx + IW'(1);
                     shreg   <= shreg >> 1;
                     tx      <= shreg[NXT];
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            PARITY: begin
               if (cnt == CNT_LAST) begin
                  cnt      <= '0;
                  stop_idx <= 1'b0;
                  tx       <= 1'b1;
                  state    <= STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               tx <= 1'b1;
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (stop_idx == 1'(STOP_BITS - 1)) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: three instances cover the default frame, the parity frame
// and the two-stop-bit frame; expected line levels are built from the configured frame layout.
module tb_serial_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] in_valid;
   logic [7:0] in_data [3];
   logic [2:0] in_ready, tx_w, busy_w, done_w;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_tx u_def (
      .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

   serial_tx #(.PARITY_EN(1)) u_par (
      .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

   serial_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_stop2 (
      .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Called at a negedge while idle; returns at the negedge of start-bit cycle 0.
   task automatic accept(input int k, input logic [7:0] d, input bit hold);
      chk($sformatf("k%0d_ready_before_accept", k), int'(in_ready[k]), 1);
      in_data[k]  = d;
      in_valid[k] = 1'b1;
      @(negedge clk);
      if (!hold) in_valid[k] = 1'b0;
   endtask

   // Samples every cycle of the frame, then the done cycle; returns at the done-cycle negedge.
   task automatic run_frame(input int k, input logic [7:0] d, input int pulse_at);
      int cpb, pe, sb, nslot, len, busy_n, done_n, rdy_n;
      logic exp_bits [0:11];
      int good [0:11];
      cpb = (k == 2) ? 4 : 16;
      pe  = (k == 1) ? 1 : 0;
      sb  = (k == 2) ? 2 : 1;
      nslot = 1 + 8 + pe + sb;
      len = cpb * nslot;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
      if (pe != 0) exp_bits[9] = ^d;
      for (int i = 9 + pe; i < nslot; i++) exp_bits[i] = 1'b1;
      for (int i = 0; i < 12; i++) good[i] = 0;
      busy_n = 0; done_n = 0; rdy_n = 0;
      for (int c = 0; c < len; c++) begin
         if (tx_w[k] === exp_bits[c / cpb]) good[c / cpb]++;
         busy_n += int'(busy_w[k]);
         done_n += int'(done_w[k]);
         rdy_n  += int'(in_ready[k]);
         if (c == pulse_at) begin
            in_data[k]  = 8'hFF;
            in_valid[k] = 1'b1;
         end else if (c == pulse_at + 1) begin
            in_valid[k] = 1'b0;
         end
         @(negedge clk);
      end
      for (int s = 0; s < nslot; s++)
         chk($sformatf("k%0d_d%02h_slot%0d_cycles", k, d, s), good[s], cpb);
      chk($sformatf("k%0d_d%02h_busy_cycles", k, d), busy_n, len);
      chk($sformatf("k%0d_d%02h_ready_cycles", k, d), rdy_n, 0);
      chk($sformatf("k%0d_d%02h_done_in_frame", k, d), done_n, 0);
      chk($sformatf("k%0d_d%02h_done_at_end", k, d), int'(done_w[k]), 1);
      chk($sformatf("k%0d_d%02h_busy_at_end", k, d), int'(busy_w[k]), 0);
      chk($sformatf("k%0d_d%02h_tx_at_end", k, d), int'(tx_w[k]), 1);
   endtask

   task automatic idle_cycles(input int k, input int n, input string tag);
      int busy_n, done_n, low_n;
      busy_n = 0; done_n = 0; low_n = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         busy_n += int'(busy_w[k]);
         done_n += int'(done_w[k]);
         low_n  += int'(!tx_w[k]);
      end
      chk({tag, "_busy"}, busy_n, 0);
      chk({tag, "_done"}, done_n, 0);
      chk({tag, "_tx_low"}, low_n, 0);
   endtask

   initial begin
      int done_n;
      in_valid = '0;
      for (int k = 0; k < 3; k++) in_data[k] = 8'h00;
      reset = 1'b1;
      #1;
      chk("reset_tx", int'(tx_w), 7);
      chk("reset_busy", int'(busy_w), 0);
      chk("reset_done", int'(done_w), 0);
      chk("reset_ready", int'(in_ready), 7);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // default frame 0xA5
      accept(0, 8'hA5, 0);
      run_frame(0, 8'hA5, -1);
      idle_cycles(0, 3, "def_after_a5");

      // parity frames: 0x07 -> parity 1, 0xA5 -> parity 0
      accept(1, 8'h07, 0);
      run_frame(1, 8'h07, -1);
      @(negedge clk);
      accept(1, 8'hA5, 0);
      run_frame(1, 8'hA5, -1);
      @(negedge clk);

      // two stop bits at 4 clocks per bit
      accept(2, 8'h3C, 0);
      run_frame(2, 8'h3C, -1);
      @(negedge clk);

      // back-to-back with in_valid held; data changes right after acceptance
      accept(0, 8'h55, 1);
      in_data[0] = 8'h0F;
      run_frame(0, 8'h55, -1);
      accept(0, 8'h0F, 0);
      run_frame(0, 8'h0F, -1);
      @(negedge clk);

      // valid pulse during DATA is ignored
      accept(0, 8'h00, 0);
      run_frame(0, 8'h00, 50);
      idle_cycles(0, 40, "ignored_pulse");

      // asynchronous reset during data bit 3
      accept(0, 8'h3C, 0);
      repeat (16 * 4 + 5) @(negedge clk);
      chk("pre_reset_busy", int'(busy_w[0]), 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_reset_tx", int'(tx_w[0]), 1);
      chk("mid_reset_busy", int'(busy_w[0]), 0);
      chk("mid_reset_ready", int'(in_ready[0]), 1);
      done_n = 0;
      repeat (3) begin
         @(negedge clk);
         done_n += int'(done_w[0]);
      end
      reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         done_n += int'(done_w[0]);
      end
      chk("reset_no_done", done_n, 0);
      accept(0, 8'h96, 0);
      run_frame(0, 8'h96, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload bits per frame (range 1..16).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the clk cycles per serial bit (minimum 2).
REQ-003 The block SHALL have parameter PARITY_EN, default 0; 1 inserts one even-parity bit after the data bits.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving the stop-bit count (1 or 2).
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_data  input  DATA_W  payload word; sampled only on an accepting edge.
REQ-008 in_valid  input  1  producer offers in_data.
REQ-009 in_ready  output  1  block can accept a word this cycle.
REQ-010 tx  output  1  registered serial line; idle level 1.
REQ-011 busy  output  1  a frame is in progress (any state other than IDLE).
REQ-012 done  output  1  single-cycle pulse marking frame completion.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-015 Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is latched into an internal shift register and the state moves to START on that edge.
REQ-016 in_valid while in_ready=0 SHALL be ignored, with no data capture and no effect on the frame in progress.
REQ-017 A bit counter SHALL count CLKS_PER_BIT cycles per bit, from 0 to CLKS_PER_BIT-1; each state or bit advances when the count reaches CLKS_PER_BIT-1.
REQ-018 In START, tx SHALL be 0 for CLKS_PER_BIT cycles, beginning the cycle after the accepting edge.
REQ-019 In DATA, tx SHALL present the DATA_W bits LSB first, each for CLKS_PER_BIT cycles.
REQ-020 In PARITY (entered only if PARITY_EN=1), tx SHALL be the XOR of all latched data bits for CLKS_PER_BIT cycles; otherwise DATA goes directly to STOP.
REQ-021 In STOP, tx SHALL be 1 for STOP_BITS*CLKS_PER_BIT cycles, after which the state returns to IDLE.
REQ-022 Frame length SHALL be CLKS_PER_BIT*(1+DATA_W+PARITY_EN+STOP_BITS) cycles; with the defaults this is 160.
REQ-023 done SHALL be 1 for exactly the first cycle back in IDLE after STOP, and 0 otherwise.
REQ-024 An accept in the same cycle that done=1 SHALL be legal, giving a back-to-back frame with no idle bit between the stop bit and the next start bit.
REQ-025 tx SHALL be 1 in IDLE and SHALL never glitch, since it is driven directly from a flop.
REQ-026 Changes on in_data after acceptance SHALL NOT affect the frame in progress.

Reset
REQ-027 While reset=1, the block SHALL immediately force state=IDLE, tx=1, busy=0, done=0, in_ready=1, and the counters and shift register to 0, independent of clk.
REQ-028 Reset asserted mid-frame SHALL abort the frame with tx=1 at once, and SHALL produce no done pulse.
REQ-029 After reset deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification
REQ-030 Defaults, accept in_data=0xA5 -> tx=0 for 16 cycles; then bits 1,0,1,0,0,1,0,1, each held 16 cycles; then tx=1 for 16 cycles; done=1 160 cycles after the start-bit cycle begins; busy=1 throughout.
REQ-031 PARITY_EN=1, in_data=0x07 -> parity bit=1; in_data=0xA5 -> parity bit=0; frame length 176 cycles.
REQ-032 in_valid held at 1 with 0x55 then 0x0F -> second start bit begins the cycle after the done pulse; no idle gap; both frames are bit-exact.
REQ-033 in_valid pulsed with 0xFF during the DATA state of a 0x00 frame -> the pulse is ignored; the frame stays all-zero data; no second frame follows.
REQ-034 reset asserted during bit 3 of a frame -> tx=1, busy=0, in_ready=1 asynchronously; no done pulse; a new accept after release transmits correctly.
REQ-035 STOP_BITS=2, CLKS_PER_BIT=4 -> tx=1 for 8 cycles before done; total frame 44 cycles.
